bg_pixel_reader: RTL
====================

BG_PIXEL_READER -- requirements
Module: bg_pixel_reader

Interface
REQ-001 Parameters: TILE_W, 20, tile width in pixels; TILE_H, 20, tile height in pixels; AW, 19, read address width.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 Clk  input  1  system clock; all state changes on rising edge.
REQ-004 Reset_n  input  1  asynchronous active-low reset.
REQ-005 frame_start  input  1  one-Clk pulse marking start of frame (top-left, before first active pixel).
REQ-006 pixel_en  input  1  pixel-rate enable; sampling happens only on edges where pixel_en=1.
REQ-007 active_video  input  1  1 = current DrawX/DrawY is a visible pixel.
REQ-008 DrawX, DrawY  input  10 each  current pixel coordinates from VGA timing.
REQ-009 scroll_x  input  5  horizontal tile offset 0..TILE_W-1, sampled only on frame_start.
REQ-010 ram_data  input  5  background frame RAM read data, registered one Clk after address.
REQ-011 read_address  output  AW  background frame RAM read address.
REQ-012 pixel_idx  output  5  palette index for aligned pixel.
REQ-013 pixel_valid  output  1  pixel_idx/pix_x/pix_y valid this cycle.
REQ-014 pix_x, pix_y  output  10 each  coordinates matching pixel_idx.

Function
REQ-015 The FSM SHALL have states WAIT_FRAME, LINE, HBLANK; reset state WAIT_FRAME.
REQ-016 WAIT_FRAME SHALL issue no fetches; pixel_valid stays 0 regardless of active_video.
REQ-017 frame_start from any state SHALL go to HBLANK, set row=0, row_base=0, col=scroll_x, latch scroll_x into scroll_q.
REQ-018 HBLANK -> LINE on an edge with pixel_en=1 and active_video=1; that edge is a fetch.
REQ-019 LINE -> HBLANK on an edge with pixel_en=1 and active_video=0; at this transition row advances (row=19 wraps to 0), row_base += TILE_W (380 wraps to 0), col=scroll_q.
REQ-020 A fetch (pixel_en=1, active_video=1, state LINE or HBLANK->LINE) SHALL register read_address = row_base + col, zero-extended to AW bits, then advance col (19 wraps to 0).
REQ-021 No multiplier SHALL be used; row_base is an incrementally maintained register, address always in 0..399.
REQ-022 Edges with pixel_en=0 SHALL hold col, row, row_base, read_address and FSM state unchanged.
REQ-023 Pipeline: fetch at edge E0; RAM registers data at E1; at E2 pixel_idx=ram_data, pix_x/pix_y = DrawX/DrawY sampled at E0, pixel_valid=1 for exactly one Clk.
REQ-024 Fetch-to-output latency SHALL be exactly 2 Clk edges, independent of pixel_en spacing; back-to-back fetches (pixel_en held 1) SHALL yield back-to-back valid outputs.
REQ-025 frame_start coinciding with a fetch edge: frame_start wins; no fetch issued that edge.
REQ-026 Fetches already in the pipeline at frame_start SHALL still complete and output.
REQ-027 When no fetch is in the E2 slot, pixel_valid=0 and pixel_idx, pix_x, pix_y hold last values.

Reset
REQ-028 Reset_n=0 SHALL asynchronously force: state=WAIT_FRAME, row=0, col=0, row_base=0, scroll_q=0, read_address=0, pixel_idx=0, pixel_valid=0, pix_x=0, pix_y=0, pipeline valid bits=0.
REQ-029 Reset mid-line SHALL discard in-flight fetches; no pixel_valid until after next frame_start and fetch.

Verification
REQ-030 Reset, then active_video=1 with pixel_en toggling for 50 Clk, no frame_start -> pixel_valid never 1, read_address=0.
REQ-031 frame_start with scroll_x=0, 25 continuous fetches on line 0 -> read_address 0..19 then 0..4; pixel_valid 2 Clk after each fetch with matching pix_x.
REQ-032 scroll_x=7, 20 lines of 3 fetches each -> line n addresses 20n+7,20n+8,20n+9; line 20 returns to 7, 8, 9.
REQ-033 pixel_en every other Clk, ram_data model = registered address low 5 bits -> pixel_idx equals expected address[4:0], latency exactly 2 Clk, pixel_valid 1-Clk wide.
REQ-034 frame_start asserted mid-line at fetch edge with 2 fetches in flight -> both in-flight pixels output, no fetch that edge, next fetch address = scroll_x.
REQ-035 Reset_n pulsed low mid-line -> all outputs 0 immediately (before next Clk edge), in-flight pixels never output.

Source files
------------

// File: rtl/bg_pixel_reader.sv
// Background tile pixel reader: walks a TILE_W x TILE_H frame RAM in raster order with a
// horizontal tile scroll, and realigns the RAM read data with its screen coordinates.
module bg_pixel_reader #(
   parameter int TILE_W = 20,
   parameter int TILE_H = 20,
   parameter int AW     = 19
) (
   input  logic          Clk,
   input  logic          Reset_n,
   input  logic          frame_start,
   input  logic          pixel_en,
   input  logic          active_video,
   input  logic [9:0]    DrawX,
   input  logic [9:0]    DrawY,
   input  logic [4:0]    scroll_x,
   input  logic [4:0]    ram_data,
   output logic [AW-1:0] read_address,
   output logic [4:0]    pixel_idx,
   output logic          pixel_valid,
   output logic [9:0]    pix_x,
   output logic [9:0]    pix_y
);

   localparam int COL_W = $clog2(TILE_W);
   localparam int ROW_W = $clog2(TILE_H);
   localparam int RB_W  = $clog2(TILE_W * TILE_H);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(TILE_W - 1);
   localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(TILE_H - 1);
   localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
   localparam logic [RB_W-1:0]  ROW_STEP = RB_W'(TILE_W);

   typedef enum logic [1:0] {
      WAIT_FRAME,
      LINE,
      HBLANK
   } state_t;

   state_t           state;
   logic [COL_W-1:0] col;
   logic [COL_W-1:0] scroll_q;
   logic [ROW_W-1:0] row;
   logic [RB_W-1:0]  row_base;
   logic [RB_W-1:0]  addr_sum;
   logic             fetch;

   logic             vld_p0;
   logic             vld_p1;
   logic [9:0]       x_p0;
   logic [9:0]       y_p0;
   logic [9:0]       x_p1;
   logic [9:0]       y_p1;

   // frame_start has priority over a fetch on the same edge
   assign fetch    = pixel_en && active_video && !frame_start &&
                     (state == LINE || state == HBLANK);
   assign addr_sum = row_base + RB_W'(col);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state        <= WAIT_FRAME;
         col          <= '0;
         scroll_q     <= '0;
         row          <= '0;
         row_base     <= '0;
         read_address <= '0;
         vld_p0       <= 1'b0;
         vld_p1       <= 1'b0;
         pixel_valid  <= 1'b0;
         pixel_idx    <= '0;
         pix_x        <= '0;
         pix_y        <= '0;
      end else begin
         // Stage p0 -> p1 -> output: advances every Clk so latency ignores pixel_en spacing
         vld_p0      <= fetch;
         vld_p1      <= vld_p0;
         pixel_valid <= vld_p1;
         if (vld_p1) begin
            pixel_idx <= ram_data;
            pix_x     <= x_p1;
            pix_y     <= y_p1;
         end

         if (frame_start) begin
            state    <= HBLANK;
            row      <= '0;
            row_base <= '0;
            col      <= COL_W'(scroll_x);
            scroll_q <= COL_W'(scroll_x);
         end else if (pixel_en) begin
            if (fetch) begin
               state        <= LINE;
               read_address <= AW'(addr_sum);
               col          <= (col == COL_LAST) ? '0 : col + COL_ONE;
            end else if (state == LINE) begin
               state    <= HBLANK;
               col      <= scroll_q;
               row      <= (row == ROW_LAST) ? '0 : row + ROW_ONE;
               row_base <= (row == ROW_LAST) ? '0 : row_base + ROW_STEP;
            end
         end
      end
   end

   // Coordinate pipeline: data only, qualified by vld_p0/vld_p1
   always_ff @(posedge Clk) begin
      if (fetch) begin
         x_p0 <= DrawX;
         y_p0 <= DrawY;
      end
      x_p1 <= x_p0;
      y_p1 <= y_p0;
   end

endmodule
